// File: rtl/troco_dispenser.sv
// Change dispenser: turns the vending FSM's 4-bit change code into greedy 50/20/10
// coin-eject requests against finite coin tubes, with a request/ack handshake to the ejector.
module troco_dispenser #(
    parameter int INIT_50    = 8,
    parameter int INIT_20    = 8,
    parameter int INIT_10    = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TROCO0,
    input  logic       TROCO1,
    input  logic       TROCO2,
    input  logic       TROCO3,
    input  logic       EJ_ACK,
    input  logic       REFILL,
    output logic       EJ50,
    output logic       EJ20,
    output logic       EJ10,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAULT,
    output logic [4:0] REM
);

    localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_GAP,
        ST_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      rem_q, rem_d;
    logic [7:0]      cnt50_q, cnt50_d;
    logic [7:0]      cnt20_q, cnt20_d;
    logic [7:0]      cnt10_q, cnt10_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            ej50_q, ej50_d;
    logic            ej20_q, ej20_d;
    logic            ej10_q, ej10_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;

    logic [3:0]      code;
    logic [2:0]      coin_paid;
    logic [6:0]      rem_sum;
    logic [4:0]      rem_next;

    assign code = {TROCO0, TROCO1, TROCO2, TROCO3};

    // Value of the coin whose release is acknowledged this cycle, in 10-cent units.
    always_comb begin
        coin_paid = 3'd0;
        if (state_q == ST_EJECT && EJ_ACK) begin
            if (ej50_q) begin
                coin_paid = 3'd5;
            end else if (ej20_q) begin
                coin_paid = 3'd2;
            end else if (ej10_q) begin
                coin_paid = 3'd1;
            end
        end
    end

    // A coin is only ever requested when REM covers it, so the subtraction cannot underflow.
    assign rem_sum  = 7'(rem_q) + 7'(code) - 7'(coin_paid);
    assign rem_next = (rem_sum > 7'd31) ? 5'd31 : rem_sum[4:0];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_next;
        cnt50_d = cnt50_q;
        cnt20_d = cnt20_q;
        cnt10_d = cnt10_q;
        gap_d   = gap_q;
        ej50_d  = ej50_q;
        ej20_d  = ej20_q;
        ej10_d  = ej10_q;
        done_d  = 1'b0;
        fault_d = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (code != 4'd0) begin
                    state_d = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (rem_q == 5'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (rem_q >= 5'd5 && cnt50_q != 8'd0) begin
                    ej50_d  = 1'b1;
                    state_d = ST_EJECT;
                end else if (rem_q >= 5'd2 && cnt20_q != 8'd0) begin
                    ej20_d  = 1'b1;
                    state_d = ST_EJECT;
                end else if (cnt10_q != 8'd0) begin
                    ej10_d  = 1'b1;
                    state_d = ST_EJECT;
                end else begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end
            end

            ST_EJECT: begin
                if (EJ_ACK) begin
                    if (ej50_q) cnt50_d = cnt50_q - 8'd1;
                    if (ej20_q) cnt20_d = cnt20_q - 8'd1;
                    if (ej10_q) cnt10_d = cnt10_q - 8'd1;
                    ej50_d  = 1'b0;
                    ej20_d  = 1'b0;
                    ej10_d  = 1'b0;
                    gap_d   = GW'(GAP_CYCLES);
                    state_d = ST_GAP;
                end
            end

            // Completion looks at the post-update amount so a code landing on this edge is not stranded in IDLE.
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (rem_next == 5'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SELECT;
                end
            end

            ST_FAULT: begin
                if (REFILL) begin
                    fault_d = 1'b0;
                    state_d = ST_SELECT;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ej50_d  = 1'b0;
                ej20_d  = 1'b0;
                ej10_d  = 1'b0;
                fault_d = 1'b0;
            end
        endcase

        // A refill overrides any same-cycle tube decrement.
        if (REFILL) begin
            cnt50_d = 8'(INIT_50);
            cnt20_d = 8'(INIT_20);
            cnt10_d = 8'(INIT_10);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            rem_q   <= 5'd0;
            cnt50_q <= 8'(INIT_50);
            cnt20_q <= 8'(INIT_20);
            cnt10_q <= 8'(INIT_10);
            gap_q   <= '0;
            ej50_q  <= 1'b0;
            ej20_q  <= 1'b0;
            ej10_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt50_q <= cnt50_d;
            cnt20_q <= cnt20_d;
            cnt10_q <= cnt10_d;
            gap_q   <= gap_d;
            ej50_q  <= ej50_d;
            ej20_q  <= ej20_d;
            ej10_q  <= ej10_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign EJ50  = ej50_q;
    assign EJ20  = ej20_q;
    assign EJ10  = ej10_q;
    assign BUSY  = (state_q != ST_IDLE);
    assign DONE  = done_q;
    assign FAULT = fault_q;
    assign REM   = rem_q;

endmodule

// File: tb/tb_troco_dispenser.sv
// Bench for troco_dispenser: directed scenarios plus random change orders, checked against
// a transaction-level greedy-change model with tube inventory.
module tb_troco_dispenser;

    localparam int GAP = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       TROCO0, TROCO1, TROCO2, TROCO3;
    logic       EJ_ACK, REFILL;
    logic       EJ50, EJ20, EJ10, BUSY, DONE, FAULT;
    logic [4:0] REM;

    int checks = 0;
    int errors = 0;

    int mRem;
    int mCnt[3];
    int initCnt[3] = '{8, 8, 8};
    int coinVal[3] = '{5, 2, 1};

    troco_dispenser #(
        .INIT_50(8), .INIT_20(8), .INIT_10(8), .GAP_CYCLES(GAP)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .TROCO0(TROCO0), .TROCO1(TROCO1), .TROCO2(TROCO2), .TROCO3(TROCO3),
        .EJ_ACK(EJ_ACK), .REFILL(REFILL),
        .EJ50(EJ50), .EJ20(EJ20), .EJ10(EJ10),
        .BUSY(BUSY), .DONE(DONE), .FAULT(FAULT), .REM(REM)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int sat31(input int v);
        return (v > 31) ? 31 : v;
    endfunction

    // Greedy choice: largest coin not exceeding the amount with stock left; -1 means cannot pay.
    function automatic int pickCoin();
        for (int i = 0; i < 3; i++) begin
            if (mRem >= coinVal[i] && mCnt[i] > 0) return i;
        end
        return -1;
    endfunction

    function automatic int ejVec();
        return int'({EJ50, EJ20, EJ10});
    endfunction

    function automatic int coinVec(input int c);
        return 4 >> c;
    endfunction

    task automatic stepClk();
        @(negedge CLK);
    endtask

    task automatic setCode(input int c);
        TROCO0 = c[3];
        TROCO1 = c[2];
        TROCO2 = c[1];
        TROCO3 = c[0];
    endtask

    task automatic modelReset();
        mRem = 0;
        mCnt = initCnt;
    endtask

    // Entered at a negedge with the DUT about to evaluate SELECT; returns after DONE has dropped.
    task automatic serveLoop(input int extraCode, input bit refillOnAck, input int ackDelay);
        int  coin;
        int  delay;
        int  n;
        int  c;
        int  iter;
        bit  first;
        bit  finished;
        first    = 1'b1;
        finished = 1'b0;
        iter     = 0;
        while (!finished && iter < 100) begin
            iter++;
            coin = pickCoin();
            if (coin < 0) begin
                stepClk();
                checkOutput("fault_flag", FAULT, 1);
                checkOutput("fault_ej", ejVec(), 0);
                checkOutput("fault_busy", BUSY, 1);
                checkOutput("fault_rem", REM, mRem);
                n = $urandom_range(1, 3);
                repeat (n) begin
                    c = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0;
                    setCode(c);
                    stepClk();
                    setCode(0);
                    mRem = sat31(mRem + c);
                    checkOutput("fault_hold", FAULT, 1);
                    checkOutput("fault_accum", REM, mRem);
                end
                REFILL = 1'b1;
                stepClk();
                REFILL = 1'b0;
                mCnt = initCnt;
                checkOutput("fault_clear", FAULT, 0);
                checkOutput("refill_busy", BUSY, 1);
                continue;
            end
            stepClk();
            checkOutput("ej_select", ejVec(), coinVec(coin));
            delay = (ackDelay < 0) ? $urandom_range(0, 3) : ackDelay;
            repeat (delay) begin
                stepClk();
                checkOutput("ej_hold", ejVec(), coinVec(coin));
            end
            EJ_ACK = 1'b1;
            if (first) begin
                setCode(extraCode);
                REFILL = refillOnAck;
            end
            stepClk();
            EJ_ACK = 1'b0;
            setCode(0);
            REFILL = 1'b0;
            mRem = sat31(mRem + (first ? extraCode : 0) - coinVal[coin]);
            if (first && refillOnAck) mCnt = initCnt;
            else mCnt[coin]--;
            checkOutput("ej_clear", ejVec(), 0);
            checkOutput("rem_after_ack", REM, mRem);
            repeat (GAP) begin
                stepClk();
                checkOutput("gap_quiet", ejVec() + (DONE ? 8 : 0), 0);
            end
            stepClk();
            if (mRem == 0) begin
                checkOutput("done_pulse", DONE, 1);
                checkOutput("done_idle", BUSY, 0);
                checkOutput("done_rem", REM, mRem);
                stepClk();
                checkOutput("done_once", DONE, 0);
                finished = 1'b1;
            end else begin
                checkOutput("no_early_done", DONE, 0);
            end
            first = 1'b0;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL serve_bound observed %0d iterations expected completion", iter);
        end
    endtask

    task automatic runOrder(input int code, input int extraCode, input bit refillOnAck, input int ackDelay);
        setCode(code);
        stepClk();
        setCode(0);
        mRem = sat31(mRem + code);
        checkOutput("start_busy", BUSY, 1);
        checkOutput("start_rem", REM, mRem);
        serveLoop(extraCode, refillOnAck, ackDelay);
    endtask

    task automatic applyStimulus();
        int coin;
        int idle;
        int code;
        int extra;
        bit rfl;

        // 70 -> 50 + 20; 90 -> 50 + 20 + 20
        runOrder(7, 0, 1'b0, 2);
        runOrder(9, 0, 1'b0, -1);

        // code arriving with the first ack of a 60 order: 6 - 5 + 1 = 2 -> 20
        runOrder(6, 1, 1'b0, 1);

        // drain the 10-cent tube, then 30 dead-ends on REM=1 and recovers after refill
        for (int i = 0; i < 8; i++) begin
            if (mCnt[2] > 0) runOrder(1, 0, 1'b0, 0);
        end
        runOrder(3, 0, 1'b0, 1);

        // refill coinciding with an ack keeps the tube full; nine 10s only then fault once
        runOrder(1, 0, 1'b1, 0);
        for (int i = 0; i < 9; i++) runOrder(1, 0, 1'b0, 0);

        // reset while a request is outstanding
        setCode(5);
        stepClk();
        setCode(0);
        mRem = 5;
        coin = pickCoin();
        stepClk();
        checkOutput("pre_reset_ej", ejVec(), coinVec(coin));
        RST_N = 1'b0;
        #1;
        checkOutput("async_reset_ej", ejVec(), 0);
        checkOutput("async_reset_busy", BUSY, 0);
        checkOutput("async_reset_rem", REM, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        modelReset();
        EJ_ACK = 1'b1;
        stepClk();
        stepClk();
        EJ_ACK = 1'b0;
        checkOutput("late_ack_ej", ejVec(), 0);
        checkOutput("late_ack_busy", BUSY, 0);
        checkOutput("late_ack_rem", REM, 0);

        // ten 100-cent codes back to back with ack withheld: REM pins at 31
        setCode(10);
        stepClk();
        mRem = sat31(mRem + 10);
        coin = pickCoin();
        checkOutput("sat_rem", REM, mRem);
        repeat (9) begin
            stepClk();
            mRem = sat31(mRem + 10);
            checkOutput("sat_rem", REM, mRem);
        end
        setCode(0);
        checkOutput("sat_final", REM, 31);
        checkOutput("sat_ej", ejVec(), coinVec(coin));
        EJ_ACK = 1'b1;
        stepClk();
        EJ_ACK = 1'b0;
        mRem = sat31(mRem - coinVal[coin]);
        mCnt[coin]--;
        checkOutput("sat_after_ack", REM, mRem);
        repeat (GAP) stepClk();
        stepClk();
        checkOutput("sat_no_done", DONE, 0);
        serveLoop(0, 1'b0, -1);

        // random orders, including codes 11..15, coincident codes and refills
        for (int k = 0; k < 30; k++) begin
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                stepClk();
                checkOutput("idle_busy", BUSY, 0);
            end
            code  = $urandom_range(1, 15);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
            rfl   = ($urandom_range(0, 9) == 0);
            runOrder(code, extra, rfl, -1);
        end
    endtask

    initial begin
        RST_N  = 1'b0;
        EJ_ACK = 1'b0;
        REFILL = 1'b0;
        setCode(0);
        modelReset();
        #1;
        checkOutput("reset_ej", ejVec(), 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_done", DONE, 0);
        checkOutput("reset_fault", FAULT, 0);
        checkOutput("reset_rem", REM, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        stepClk();
        checkOutput("post_reset_busy", BUSY, 0);
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
